// File: rtl/pulse_gen.sv
// Programmable periodic waveform source with glitch-free config updates.
// Period/high time in clk cycles; new settings apply only at period boundaries.
module pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             out_wire,
    output logic             period_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_r, high_r;
    logic [CNT_W-1:0] shadow_period, shadow_high;
    logic             pending;

    logic             last;
    logic             xfer;
    logic             apply;
    logic [CNT_W-1:0] legal_period;

    assign last         = (cnt == period_r - 1'b1);
    assign xfer         = cfg_valid && cfg_ready;
    // Idle applies immediately so re-enable always starts on the new config.
    assign apply        = pending && (!en || last);
    assign legal_period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            out_wire      <= 1'b0;
            period_tick   <= 1'b0;
            cfg_ready     <= 1'b1;
            pending       <= 1'b0;
            period_r      <= CNT_W'(2);
            high_r        <= CNT_W'(1);
            shadow_period <= CNT_W'(2);
            shadow_high   <= CNT_W'(1);
        end else begin
            if (en) begin
                cnt         <= last ? '0 : cnt + 1'b1;
                out_wire    <= (cnt < high_r);
                period_tick <= last;
            end else begin
                cnt         <= '0;
                out_wire    <= 1'b0;
                period_tick <= 1'b0;
            end

            // xfer implies pending=0, so it can never race an apply.
            if (apply) begin
                period_r  <= shadow_period;
                high_r    <= shadow_high;
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end else if (xfer) begin
                shadow_period <= legal_period;
                shadow_high   <= cfg_high;
                pending       <= 1'b1;
                cfg_ready     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: directed scenarios plus random traffic,
// compared cycle by cycle against a phase/period reference model.
module tb_pulse_gen;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_ready;
    logic             out_wire;
    logic             period_tick;

    pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .out_wire    (out_wire),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: position within the current period, active waveform, queued waveform.
    int m_phase, m_len, m_hi, q_len, q_hi;
    bit m_queued;
    bit e_out, e_tick, e_rdy;

    function automatic void model_reset();
        m_phase = 0; m_len = 2; m_hi = 1; m_queued = 0;
        q_len = 2; q_hi = 1;
        e_out = 0; e_tick = 0; e_rdy = 1;
    endfunction

    function automatic void model_step();
        bit end_of_period;
        end_of_period = en && (m_phase == m_len - 1);
        if (en) begin
            e_out   = (m_phase < m_hi);
            e_tick  = end_of_period;
            m_phase = (m_phase + 1) % m_len;
        end else begin
            e_out = 0; e_tick = 0; m_phase = 0;
        end
        if (m_queued && (!en || end_of_period)) begin
            m_len = q_len; m_hi = q_hi; m_queued = 0; e_rdy = 1;
        end else if (cfg_valid && e_rdy) begin
            q_len = (cfg_period < 2) ? 2 : int'(cfg_period);
            q_hi  = int'(cfg_high);
            m_queued = 1; e_rdy = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; cfg_valid = 0; cfg_period = 0; cfg_high = 0;
        model_reset();
        #12;
        n_checks++;
        if ({out_wire, period_tick, cfg_ready} !== 3'b001)
            $display("FAIL reset_values got=%b want=001", {out_wire, period_tick, cfg_ready});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_default_clk2();
        en = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy} ||
                out_wire !== ((k % 2) == 0) || period_tick !== ((k % 2) == 1))
                $display("FAIL default_clk2 k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
        en = 0;
        step();
    endtask

    task automatic load_idle(input int p, input int h);
        cfg_valid = 1; cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
        step();
        cfg_valid = 0;
        n_checks++;
        if (cfg_ready !== 1'b0 || e_rdy !== 1'b0)
            $display("FAIL handshake_ready_low got=%b want=0", cfg_ready);
        else n_pass++;
        step();
        n_checks++;
        if (cfg_ready !== 1'b1)
            $display("FAIL idle_apply_ready got=%b want=1", cfg_ready);
        else n_pass++;
    endtask

    task automatic test_load_5_2();
        bit pat [5] = '{1, 1, 0, 0, 0};
        load_idle(5, 2);
        en = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy} ||
                out_wire !== pat[k % 5] || period_tick !== ((k % 5) == 4))
                $display("FAIL load_5_2 k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
        en = 0;
        step();
    endtask

    task automatic test_midperiod_reconfig();
        bit pat [10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        load_idle(4, 1);
        en = 1;
        step(); // phase 0 output
        cfg_valid = 1; cfg_period = 6; cfg_high = 3;
        step(); // transfer
        cfg_period = 2; cfg_high = 2; // second offer while busy must be dropped
        for (int k = 2; k < 10; k++) begin
            if (k == 3) cfg_valid = 0;
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy} ||
                out_wire !== pat[k] || cfg_ready !== (k >= 3))
                $display("FAIL midperiod k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
        en = 0;
        step();
    endtask

    task automatic test_legalise();
        int cases [4][3] = '{'{0, 1, 2}, '{1, 1, 2}, '{5, 0, 5}, '{5, 9, 5}};
        int ticks;
        for (int c = 0; c < 4; c++) begin
            load_idle(cases[c][0], cases[c][1]);
            en = 1;
            ticks = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                ticks += period_tick;
                n_checks++;
                if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy})
                    $display("FAIL legalise c=%0d k=%0d got=%b want=%b", c, k,
                             {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
                else n_pass++;
            end
            n_checks++;
            if (ticks !== 10 / cases[c][2])
                $display("FAIL legalise_ticks c=%0d got=%0d want=%0d", c, ticks, 10 / cases[c][2]);
            else n_pass++;
            en = 0;
            step();
        end
    endtask

    task automatic test_en_drop();
        load_idle(5, 2);
        en = 1;
        repeat (3) step(); // cnt now at 3 after consuming phases 0..2
        en = 0;
        step();
        n_checks++;
        if ({out_wire, period_tick} !== 2'b00)
            $display("FAIL en_drop got=%b want=00", {out_wire, period_tick});
        else n_pass++;
        step();
        en = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy} ||
                (k < 2 && out_wire !== 1'b1))
                $display("FAIL en_restart k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        // en still 1 running period 5; queue a config then reset before it lands
        cfg_valid = 1; cfg_period = 7; cfg_high = 4;
        step();
        cfg_valid = 0;
        #1 rst_n = 0;
        #1;
        n_checks++;
        if ({out_wire, period_tick, cfg_ready} !== 3'b001)
            $display("FAIL async_reset got=%b want=001", {out_wire, period_tick, cfg_ready});
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy} ||
                out_wire !== ((k % 2) == 0))
                $display("FAIL post_reset k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if (!(cfg_valid && !cfg_ready)) begin
                cfg_valid  = ($urandom_range(0, 7) == 0);
                cfg_period = CNT_W'($urandom_range(0, 12));
                cfg_high   = CNT_W'($urandom_range(0, 13));
            end
            step();
            n_checks++;
            if ({out_wire, period_tick, cfg_ready} !== {e_out, e_tick, e_rdy})
                $display("FAIL random k=%0d got=%b want=%b", k,
                         {out_wire, period_tick, cfg_ready}, {e_out, e_tick, e_rdy});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_default_clk2();
        test_load_5_2();
        test_midperiod_reconfig();
        test_legalise();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
